// File: rtl/pi_channel_scheduler_pkg.sv
// Shared constants for the PI channel scheduler: operand width, default
// datapath latency and the FSM state encoding.
package pi_channel_scheduler_pkg;

    localparam int DP_W    = 64;
    localparam int DEF_LAT = 19;

    typedef logic [DP_W-1:0] dword_t;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_ISSUE  = 2'd1;
    localparam state_t ST_WAIT   = 2'd2;
    localparam state_t ST_COMMIT = 2'd3;

endpackage

// File: rtl/pi_channel_scheduler_rr_arbiter.sv
// Round-robin arbiter: searches the request vector starting at the channel
// after the last grant and returns the winner as one-hot and as an index.
module rr_arbiter #(
    parameter int N_CH = 4
) (
    input  logic [N_CH-1:0]         req,
    input  logic [$clog2(N_CH)-1:0] last,
    output logic [N_CH-1:0]         gnt,
    output logic [$clog2(N_CH)-1:0] idx
);
    localparam int IW = $clog2(N_CH);

    logic found;
    int   cand;

    always_comb begin
        // NOTE: every output gets a default before the search so no path leaves it unassigned (no latch).
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        cand  = 0;
        for (int k = 1; k <= N_CH; k++) begin
            cand = (int'(last) + k) % N_CH;
            if (!found && req[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                idx       = IW'(cand);
            end
        end
    end

endmodule

// File: rtl/pi_channel_scheduler.sv
// Time-multiplexes one shared PI datapath across N_CH channels, keeping each
// channel's x/y history and committing results in round-robin order.
module pi_channel_scheduler
    import pi_channel_scheduler_pkg::*;
#(
    parameter int N_CH = 4,
    parameter int LAT  = DEF_LAT,
    parameter int TMO  = 24
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr_state,
    input  logic [N_CH-1:0]         req,
    input  logic [DP_W*N_CH-1:0]    x_in,
    output logic [N_CH-1:0]         done,
    output logic [DP_W-1:0]         y_out,
    output logic [$clog2(N_CH)-1:0] y_ch,
    output logic                    busy,
    output logic                    err,
    output logic                    dp_sta,
    output logic [DP_W-1:0]         dp_x,
    output logic [DP_W-1:0]         dp_x_prev,
    output logic [DP_W-1:0]         dp_y_prev,
    input  logic                    dp_done,
    input  logic [DP_W-1:0]         dp_y
);
    localparam int IW = $clog2(N_CH);
    localparam int CW = $clog2(TMO);

    if (TMO <= LAT) begin : g_bad_tmo
        $error("pi_channel_scheduler: TMO must exceed LAT");
    end

    state_t          state;
    logic [IW-1:0]   rr_ptr;
    logic [IW-1:0]   last_gnt;
    logic [IW-1:0]   next_ptr;
    logic [IW-1:0]   arb_idx;
    logic [IW-1:0]   gnt_idx;
    logic [N_CH-1:0] arb_gnt;
    logic [N_CH-1:0] gnt_oh;
    logic [CW-1:0]   wait_cnt;

    dword_t x_ch   [N_CH];
    dword_t x_prev [N_CH];
    dword_t y_prev [N_CH];

    for (genvar i = 0; i < N_CH; i++) begin : g_unpack
        assign x_ch[i] = x_in[i*DP_W +: DP_W];
    end

    // rr_ptr is the first channel to search; the arbiter wants the one before it.
    assign last_gnt = (rr_ptr == '0) ? IW'(N_CH - 1) : rr_ptr - 1'b1;
    assign next_ptr = (arb_idx == IW'(N_CH - 1)) ? '0 : arb_idx + 1'b1;

    rr_arbiter #(.N_CH(N_CH)) u_arb (
        .req  (req),
        .last (last_gnt),
        .gnt  (arb_gnt),
        .idx  (arb_idx)
    );

    assign busy = (state != ST_IDLE);
    // A clear arriving in COMMIT cancels the commit, so done is gated combinationally.
    assign done = (state == ST_COMMIT && !clr_state) ? gnt_oh : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            rr_ptr    <= '0;
            gnt_idx   <= '0;
            gnt_oh    <= '0;
            wait_cnt  <= '0;
            err       <= 1'b0;
            dp_sta    <= 1'b0;
            dp_x      <= '0;
            dp_x_prev <= '0;
            dp_y_prev <= '0;
            y_out     <= '0;
            y_ch      <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register updates from pre-edge values.
            dp_sta <= 1'b0;
            if (clr_state) begin
                state <= ST_IDLE;
                err   <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (|req) begin
                            state     <= ST_ISSUE;
                            gnt_idx   <= arb_idx;
                            gnt_oh    <= arb_gnt;
                            rr_ptr    <= next_ptr;
                            dp_sta    <= 1'b1;
                            dp_x      <= x_ch[arb_idx];
                            dp_x_prev <= x_prev[arb_idx];
                            dp_y_prev <= y_prev[arb_idx];
                        end
                    end
                    ST_ISSUE: begin
                        state    <= ST_WAIT;
                        wait_cnt <= '0;
                    end
                    ST_WAIT: begin
                        if (dp_done) begin
                            state <= ST_COMMIT;
                            y_out <= dp_y;
                            y_ch  <= gnt_idx;
                        end else if (wait_cnt == CW'(TMO - 1)) begin
                            state <= ST_IDLE;
                            err   <= 1'b1;
                        end else begin
                            wait_cnt <= wait_cnt + 1'b1;
                        end
                    end
                    ST_COMMIT: state <= ST_IDLE;
                    default:   state <= ST_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: history lives in flops rather than RAM so it can be reset and bulk-cleared in one cycle.
            for (int i = 0; i < N_CH; i++) begin
                x_prev[i] <= '0;
                y_prev[i] <= '0;
            end
        end else if (clr_state) begin
            for (int i = 0; i < N_CH; i++) begin
                x_prev[i] <= '0;
                y_prev[i] <= '0;
            end
        end else if (state == ST_COMMIT) begin
            x_prev[gnt_idx] <= dp_x;
            y_prev[gnt_idx] <= y_out;
        end
    end

endmodule
